// File: rtl/sqrt_request_arbiter.sv
// sqrt_request_arbiter
//   Round-robin arbiter/sequencer sharing one fixed-point square-root unit among NUM_REQ
//   requesters. At most one operand is issued per cycle. A tag pipeline matched to the
//   unit latency routes each result back to its owner as a one-cycle done pulse.
//
// Ports
//   Clock, Reset       : clock, synchronous active-high reset
//   iRequest           : per-requester level request
//   iOperand           : requester i operand at [i*OPERAND_W +: OPERAND_W]
//   oGrant             : one-hot pulse, operand accepted
//   oBusy              : requester has an operation in flight
//   oDone              : one-hot pulse, oResult valid for that requester
//   oResult            : result, valid while any oDone bit is high
//   oRangeError        : operand integer part beyond LUT range, valid with oDone
//   oSqrtOperand       : operand to the square-root unit
//   oSqrtInputReady    : issue strobe to the square-root unit
//   iSqrtOutputReady   : square-root unit result strobe
//   iSqrtResult        : square-root unit result
//   oProtocolError     : sticky, result strobe disagreed with the tag pipeline
module sqrt_request_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned OPERAND_W = 64,
  parameter int unsigned RESULT_W  = 32,
  parameter int unsigned SCALE     = 17
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [NUM_REQ-1:0]             iRequest,
  input  logic [NUM_REQ*OPERAND_W-1:0]   iOperand,
  output logic [NUM_REQ-1:0]             oGrant,
  output logic [NUM_REQ-1:0]             oBusy,
  output logic [NUM_REQ-1:0]             oDone,
  output logic [RESULT_W-1:0]            oResult,
  output logic                           oRangeError,
  output logic [OPERAND_W-1:0]           oSqrtOperand,
  output logic                           oSqrtInputReady,
  input  logic                           iSqrtOutputReady,
  input  logic [RESULT_W-1:0]            iSqrtResult,
  output logic                           oProtocolError
);

  localparam int unsigned Depth    = LATENCY + 1;
  // Integer part >= 8192 cannot be served by the LUT plus the /64 scaling.
  localparam int unsigned RangeLsb = SCALE + 13;

  logic [NUM_REQ-1:0]            busy_q;
  logic [IDX_W-1:0]              ptr_q;
  logic [Depth-1:0]              tag_vld_q;
  logic [Depth-1:0]              tag_rerr_q;
  logic [Depth-1:0][IDX_W-1:0]   tag_idx_q;

  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            grant_vec;
  logic [IDX_W-1:0]              win;
  logic [IDX_W-1:0]              cand_idx;
  logic                          any_elig;
  logic [OPERAND_W-1:0]          sel_operand;
  logic                          sel_range_err;
  logic                          cmpl;
  logic [NUM_REQ-1:0]            cmpl_vec;

  assign oBusy = busy_q;

  // A requester on its done cycle is excluded so it cannot be re-granted on its own completion.
  assign eligible = iRequest & ~busy_q & ~oDone;

  // Round-robin search starting just after the last winner.
  always_comb begin
    any_elig = 1'b0;
    win      = ptr_q;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((32'(ptr_q) + 32'(k) + 32'd1) % 32'(NUM_REQ));
      if (!any_elig && eligible[cand_idx]) begin
        any_elig = 1'b1;
        win      = cand_idx;
      end
    end
  end

  assign grant_vec = any_elig ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    sel_operand = iOperand[OPERAND_W-1:0];
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win == IDX_W'(i)) begin
        sel_operand = iOperand[i*OPERAND_W +: OPERAND_W];
      end
    end
  end

  assign sel_range_err = |sel_operand[OPERAND_W-1:RangeLsb];

  // The last tag stage lines up with the unit's result strobe.
  assign cmpl     = iSqrtOutputReady & tag_vld_q[LATENCY];
  assign cmpl_vec = NUM_REQ'(1) << tag_idx_q[LATENCY];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      busy_q          <= '0;
      ptr_q           <= IDX_W'(NUM_REQ - 1);
      tag_vld_q       <= '0;
      tag_rerr_q      <= '0;
      tag_idx_q       <= '0;
      oGrant          <= '0;
      oDone           <= '0;
      oResult         <= '0;
      oRangeError     <= 1'b0;
      oSqrtOperand    <= '0;
      oSqrtInputReady <= 1'b0;
      oProtocolError  <= 1'b0;
    end else begin
      oSqrtInputReady <= any_elig;
      oGrant          <= grant_vec;
      if (any_elig) begin
        oSqrtOperand <= sel_operand;
        ptr_q        <= win;
      end

      // Clear happens at the end of the done cycle; a grant never targets that requester.
      busy_q <= (busy_q & ~oDone) | grant_vec;

      tag_vld_q[0]  <= any_elig;
      tag_idx_q[0]  <= win;
      tag_rerr_q[0] <= sel_range_err;
      for (int unsigned k = 1; k < Depth; k++) begin
        tag_vld_q[k]  <= tag_vld_q[k-1];
        tag_idx_q[k]  <= tag_idx_q[k-1];
        tag_rerr_q[k] <= tag_rerr_q[k-1];
      end

      oDone       <= cmpl ? cmpl_vec : '0;
      oRangeError <= cmpl & tag_rerr_q[LATENCY];
      if (cmpl) begin
        oResult <= iSqrtResult;
      end

      if (iSqrtOutputReady != tag_vld_q[LATENCY]) begin
        oProtocolError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Bench for sqrt_request_arbiter. A one-cycle stub stands in for the square-root unit and
// returns operand >> 1 so every result is easy to hand-compute and unique per operand.
// Expected grants and completions are queued by the stimulus and checked by a monitor.
module tb_sqrt_request_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned OW = 64;
  localparam int unsigned RW = 32;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [NR-1:0]     iRequest;
  logic [NR*OW-1:0]  iOperand;
  logic [NR-1:0]     oGrant;
  logic [NR-1:0]     oBusy;
  logic [NR-1:0]     oDone;
  logic [RW-1:0]     oResult;
  logic              oRangeError;
  logic [OW-1:0]     oSqrtOperand;
  logic              oSqrtInputReady;
  logic              iSqrtOutputReady;
  logic [RW-1:0]     iSqrtResult;
  logic              oProtocolError;

  logic              stub_vld;
  logic [RW-1:0]     stub_res;
  logic              inject;

  always #5 Clock = ~Clock;

  sqrt_request_arbiter #(
    .NUM_REQ  (NR),
    .IDX_W    (IW),
    .LATENCY  (1),
    .OPERAND_W(OW),
    .RESULT_W (RW),
    .SCALE    (17)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .iRequest        (iRequest),
    .iOperand        (iOperand),
    .oGrant          (oGrant),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oResult         (oResult),
    .oRangeError     (oRangeError),
    .oSqrtOperand    (oSqrtOperand),
    .oSqrtInputReady (oSqrtInputReady),
    .iSqrtOutputReady(iSqrtOutputReady),
    .iSqrtResult     (iSqrtResult),
    .oProtocolError  (oProtocolError)
  );

  // Square-root unit stub with latency 1.
  always @(posedge Clock) begin
    if (Reset) begin
      stub_vld <= 1'b0;
      stub_res <= '0;
    end else begin
      stub_vld <= oSqrtInputReady;
      stub_res <= oSqrtOperand[RW:1];
    end
  end

  assign iSqrtOutputReady = stub_vld | inject;
  assign iSqrtResult      = stub_res;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [RW-1:0] res;
    logic          rerr;
  } done_t;

  logic [IW-1:0] exp_grant[$];
  done_t         exp_done[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [NR-1:0] drop_on_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every grant and done pulse must match the head of its queue.
  logic [IW-1:0] mon_g;
  done_t         mon_d;
  always @(negedge Clock) begin
    if (oGrant != '0) begin
      if (exp_grant.size() == 0) begin
        check("unexpected_grant", 64'(oGrant), 64'd0);
      end else begin
        mon_g = exp_grant.pop_front();
        check("grant_order", 64'(oGrant), 64'(1) << mon_g);
      end
    end
    if (oDone != '0) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 64'(oDone), 64'd0);
      end else begin
        mon_d = exp_done.pop_front();
        check("done_owner", 64'(oDone), 64'(1) << mon_d.idx);
        check("done_result", 64'(oResult), 64'(mon_d.res));
        check("done_range", 64'(oRangeError), 64'(mon_d.rerr));
      end
    end
  end

  task automatic step();
    @(negedge Clock);
    for (int i = 0; i < int'(NR); i++) begin
      if (oDone[i] && drop_on_done[i]) iRequest[i] = 1'b0;
    end
  endtask

  task automatic set_op(input int i, input logic [OW-1:0] val);
    iOperand[i*OW +: OW] = val;
  endtask

  task automatic push_op(input int i, input logic [RW-1:0] res, input logic rerr);
    done_t d;
    d.idx  = IW'(i);
    d.res  = res;
    d.rerr = rerr;
    exp_grant.push_back(IW'(i));
    exp_done.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_done.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(name, 64'(exp_grant.size() + exp_done.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    iRequest     = '0;
    iOperand     = '0;
    inject       = 1'b0;
    drop_on_done = '1;
    repeat (3) step();

    // Reset state
    check("rst_grant", 64'(oGrant), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_issue", 64'(oSqrtInputReady), 64'd0);
    check("rst_proto", 64'(oProtocolError), 64'd0);
    check("rst_result", 64'(oResult), 64'd0);
    Reset = 1'b0;

    // Single request: 4.0 -> stub 0x40000, grant at t+1, done at t+3
    set_op(0, 64'h0000_0000_0008_0000);
    push_op(0, 32'h0004_0000, 1'b0);
    iRequest[0] = 1'b1;
    step();
    check("single_grant_t1", 64'(oGrant), 64'h1);
    step();
    check("single_grant_pulse", 64'(oGrant), 64'h0);
    check("single_busy", 64'(oBusy), 64'h1);
    step();
    check("single_done_t3", 64'(oDone), 64'h1);
    check("single_result", 64'(oResult), 64'h0004_0000);
    wait_drain("single_drain", 20);
    step();
    check("single_busy_clear", 64'(oBusy), 64'h0);

    // Range flag: integer part 8192 flagged, 8191 not
    set_op(1, 64'h0000_0000_4000_0000);
    push_op(1, 32'h2000_0000, 1'b1);
    iRequest[1] = 1'b1;
    wait_drain("range_hi_drain", 20);
    set_op(3, 64'h0000_0000_3FFE_0000);
    push_op(3, 32'h1FFF_0000, 1'b0);
    iRequest[3] = 1'b1;
    wait_drain("range_lo_drain", 20);
    step();

    // Contention: all four request at once, pointer sits at 3 -> order 0,1,2,3
    set_op(0, 64'h100);
    set_op(1, 64'h200);
    set_op(2, 64'h300);
    set_op(3, 64'h400);
    push_op(0, 32'h80, 1'b0);
    push_op(1, 32'h100, 1'b0);
    push_op(2, 32'h180, 1'b0);
    push_op(3, 32'h200, 1'b0);
    iRequest = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      check("contention_consecutive", 64'(oGrant), 64'(1) << k);
    end
    wait_drain("contention_drain", 30);
    step();
    check("contention_idle", 64'(oBusy), 64'h0);

    // Fairness: 0 and 2 keep requesting -> grants alternate 0,2,0,2
    drop_on_done = '0;
    set_op(0, 64'h1000);
    set_op(2, 64'h2000);
    push_op(0, 32'h800, 1'b0);
    push_op(2, 32'h1000, 1'b0);
    push_op(0, 32'h800, 1'b0);
    push_op(2, 32'h1000, 1'b0);
    iRequest = 4'b0101;
    for (int n = 0; n < 30 && exp_grant.size() != 0; n++) step();
    iRequest     = '0;
    drop_on_done = '1;
    wait_drain("fair_drain", 30);
    repeat (3) step();
    check("pre_proto_clean", 64'(oProtocolError), 64'd0);

    // Reset the cycle after granting requester 1: no done, busy cleared, pointer reset
    set_op(1, 64'h5000);
    exp_grant.push_back(IW'(1));
    iRequest[1] = 1'b1;
    step();
    check("rst_mid_grant", 64'(oGrant), 64'h2);
    step();
    Reset    = 1'b1;
    iRequest = '0;
    step();
    Reset = 1'b0;
    check("rst_mid_busy", 64'(oBusy), 64'h0);
    check("rst_mid_done", 64'(oDone), 64'h0);
    repeat (3) step();
    check("rst_mid_busy_later", 64'(oBusy), 64'h0);
    check("rst_mid_proto", 64'(oProtocolError), 64'd0);
    set_op(0, 64'h6000);
    push_op(0, 32'h3000, 1'b0);
    push_op(1, 32'h2800, 1'b0);
    iRequest = 4'b0011;
    step();
    check("rst_first_grant", 64'(oGrant), 64'h1);
    wait_drain("rst_after_drain", 30);
    step();

    // Protocol error: stray strobe with no issue
    inject = 1'b1;
    step();
    inject = 1'b0;
    check("proto_set", 64'(oProtocolError), 64'd1);
    repeat (4) step();
    check("proto_sticky", 64'(oProtocolError), 64'd1);
    check("proto_busy", 64'(oBusy), 64'h0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("proto_cleared", 64'(oProtocolError), 64'd0);
    repeat (2) step();
    check("final_queues", 64'(exp_grant.size() + exp_done.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt_request_arbiter.md
Name: sqrt_request_arbiter

Overview:
Round-robin arbiter and sequencer that shares one FixedPointSquareRoot instance among NUM_REQ requesters (execution cores / ray units).
- Accepts level requests and issues at most one operand per cycle into the square-root unit.
- Tracks in-flight operations with a tag pipeline matched to the unit latency.
- Routes each result back to its owner with a one-cycle done pulse, plus an out-of-range flag.

Parameters:
NUM_REQ, 4, number of requesters
IDX_W, 2, requester index width (log2 NUM_REQ)
LATENCY, 1, square-root unit latency in cycles from oSqrtInputReady to iSqrtOutputReady
OPERAND_W, 64 (`GPU_LONGWORD), operand width
RESULT_W, 32 (`GPU_WORD), result width
SCALE, 17 (`SCALE), fixed-point fraction bits

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
iRequest  in  NUM_REQ  per-requester level request
iOperand  in  NUM_REQ*OPERAND_W  requester i operand at [i*OPERAND_W +: OPERAND_W]
oGrant  out  NUM_REQ  one-hot, one-cycle pulse: operand accepted
oBusy  out  NUM_REQ  requester has an operation in flight
oDone  out  NUM_REQ  one-hot, one-cycle pulse: oResult is valid for that requester
oResult  out  RESULT_W  result, valid only while any oDone bit is high
oRangeError  out  1  operand exceeded the LUT range; valid with oDone
oSqrtOperand  out  OPERAND_W  operand to the square-root unit
oSqrtInputReady  out  1  issue strobe to the square-root unit
iSqrtOutputReady  in  1  square-root unit result strobe
iSqrtResult  in  RESULT_W  square-root unit result
oProtocolError  out  1  sticky flag: result strobe / tag mismatch

Behaviour:
- Reset values:
  - All outputs 0, busy[] = 0, tag pipeline empty.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - In-flight results are discarded; a reset mid-operation produces no oDone.
- Eligibility: eligible[i] = iRequest[i] & ~busy[i] & ~oDone[i].
- Arbitration:
  - Search starts at pointer+1 modulo NUM_REQ; the first eligible index W wins.
  - The pointer updates to W only when a grant occurs.
- Issue (edge ending cycle t, when any requester is eligible):
  - oSqrtInputReady <= 1, oSqrtOperand <= operand[W], oGrant <= onehot(W), busy[W] <= 1.
  - Tag pipeline stage 0 <= {valid=1, idx=W, rangeErr}.
- rangeErr = |operand[W][OPERAND_W-1 : SCALE+13]. Integer part >= 8192 is unsupported by the LUT plus the /64 scaling.
- When no requester is eligible: oSqrtInputReady <= 0, oGrant <= 0, oSqrtOperand holds its previous value.
- Tag pipeline:
  - LATENCY+1 stages deep; advances every cycle.
  - The stage aligned with iSqrtOutputReady is compared against it.
- Completion (cycle where iSqrtOutputReady = 1 and the aligned tag is valid): next edge sets oResult <= iSqrtResult, oDone <= onehot(idx), oRangeError <= tag.rangeErr.
- busy[idx] clears at the edge ending the oDone cycle. The requester must drop iRequest for the cycle after oDone, or it is treated as a new request.
- Latency: request seen in cycle t -> oGrant in t+1 -> oDone in t+LATENCY+2 (t+3 for LATENCY=1).
- Throughput: one issue per cycle across requesters. A single requester has at most one operation in flight. Max in flight = min(NUM_REQ, LATENCY+1).
- Simultaneous events:
  - Issue and completion in the same cycle are independent.
  - A requester whose oDone is high is ineligible that cycle, so it cannot be re-granted on its own completion edge.
- Protocol error: iSqrtOutputReady differs from the aligned tag valid bit -> oProtocolError <= 1, sticky until Reset. The stray strobe produces no oDone; a missing strobe leaves busy[idx] set.

Test Plan:
- Single request: iRequest=0001, operand 0x0000_0000_0008_0000; stub returns 0x0004_0000 -> oGrant=0001 at t+1, oDone=0001 with oResult=0x00040000, oRangeError=0 at t+3; busy[0] clear after.
- Contention: iRequest=1111 held, each requester drops its request after its oDone -> grant order 0,1,2,3 on consecutive cycles; four oDone pulses in the same order, each with its own result; no duplicate grants.
- Round-robin fairness: requesters 0 and 2 re-request immediately after each done -> grants alternate 0,2,0,2; requester 0 never wins twice in a row while 2 is waiting.
- Range flag: operand 0x0000_0000_4000_0000 (integer part 8192) -> oRangeError=1 with its oDone; operand 0x0000_0000_3FFE_0000 -> 0.
- Reset mid-flight: assert Reset the cycle after oGrant=0010 -> no oDone follows; oBusy=0000; the next request is granted to requester 0 first.
- Protocol: inject iSqrtOutputReady=1 with no issue -> oProtocolError=1 and stays 1 until Reset; no oDone.
